regfile_wr_arbiter: RTL

//  Shares the register file's single write port (write enable/addr/data) between two writeback sources.

---
 rtl/regfile_wr_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: two FIFO-buffered writeback sources round-robin shared onto one registered regfile write port
module regfile_wr_arbiter #(
    parameter int REG_SIZE = 16,
    parameter int ADDR_W   = 4,
    parameter int NREGS    = 10,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [REG_SIZE-1:0] a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [REG_SIZE-1:0] b_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [REG_SIZE-1:0] wr_data,
    output logic [NREGS-1:0]    pend_mask,
    output logic                idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [ADDR_W-1:0]   fa [2][DEPTH];
    logic [REG_SIZE-1:0] fd [2][DEPTH];
    logic [PW-1:0]       rp [2];
    logic [PW-1:0]       wp [2];
    logic [CW-1:0]       cnt [2];
    logic [ADDR_W-1:0]   in_a [2];
    logic [REG_SIZE-1:0] in_d [2];
    logic [1:0]          in_v, full, nemp, push, pop;
    logic                last_gnt, gnt_b;
    always_comb begin
        in_v = {b_valid, a_valid};
        in_a[0] = a_addr;
        in_a[1] = b_addr;
        in_d[0] = a_data;
        in_d[1] = b_data;
        full = '0;
        nemp = '0;
        push = '0;
        for (int s = 0; s < 2; s++) begin
            full[s] = cnt[s] == CW'(DEPTH);
            nemp[s] = cnt[s] != '0;
            push[s] = in_v[s] & ~full[s];
        end
        gnt_b = nemp[1] & (~nemp[0] | ~last_gnt);
        pop = {gnt_b, nemp[0] & ~gnt_b};
    end
    // Out-of-range addresses shift past the top bit and mark nothing
    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        pend_mask = wr_en ? NREGS'(1) << wr_addr : '0;
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                off = PW'(e) - rp[s];
                if (CW'(off) < cnt[s]) pend_mask = pend_mask | (NREGS'(1) << fa[s][e]);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                rp[s] <= '0;
                wp[s] <= '0;
                cnt[s] <= '0;
            end
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            last_gnt <= 1'b1;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    fa[s][wp[s]] <= in_a[s];
                    fd[s][wp[s]] <= in_d[s];
                    wp[s] <= wp[s] + PW'(1);
                end
                if (pop[s]) rp[s] <= rp[s] + PW'(1);
                cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
            end
            wr_en <= |nemp;
            if (|nemp) begin
                wr_addr <= fa[gnt_b][rp[gnt_b]];
                wr_data <= fd[gnt_b][rp[gnt_b]];
                last_gnt <= gnt_b;
            end
        end
    end
    assign a_ready = ~full[0];
    assign b_ready = ~full[1];
    assign idle = ~|nemp & ~wr_en;
endmodule
